// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: cpu port, DMA/loader port, RAM port and grant.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 16
);
  // cpu port
  logic [1:0]    cpu_cmd;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_wait;
  // DMA / loader port
  logic          dma_valid;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ready;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;
  // RAM port
  logic [AW-1:0] ram_addr;
  logic          ram_write;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  // current/last owner
  logic          gnt_dma;

  modport slave (
    input  cpu_cmd, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_wait,
    input  dma_valid, dma_we, dma_addr, dma_wdata,
    output dma_ready, dma_rvalid, dma_rdata,
    output ram_addr, ram_write, ram_din,
    input  ram_dout,
    output gnt_dma
  );

  modport master (
    output cpu_cmd, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_wait,
    output dma_valid, dma_we, dma_addr, dma_wdata,
    input  dma_ready, dma_rvalid, dma_rdata,
    input  ram_addr, ram_write, ram_din,
    output ram_dout,
    input  gnt_dma
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-ported RAM between the cpu
// and a DMA/loader port. Each access is IDLE(grant) -> ACCESS -> RESP.
module mem_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          ramwr_q, ramwr_d;
  logic [DW-1:0] crd_q, crd_d;
  logic [DW-1:0] drd_q, drd_d;

  logic cpu_req, dma_req, pick_dma, grant_wr;

  assign cpu_req  = (bus.cpu_cmd == 2'b01) || (bus.cpu_cmd == 2'b10);
  assign dma_req  = bus.dma_valid;
  // On a tie the port that did not win last time gets the RAM.
  assign pick_dma = dma_req && (!cpu_req || !last_q);
  assign grant_wr = pick_dma ? bus.dma_we : (bus.cpu_cmd == 2'b10);

  // Next-state: arbitration in IDLE, RAM strobe in ACCESS, read capture in RESP.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    din_d   = din_q;
    ramwr_d = ramwr_q;
    crd_d   = crd_q;
    drd_d   = drd_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req || dma_req) begin
          gnt_d   = pick_dma;
          last_d  = pick_dma;
          wr_d    = grant_wr;
          ramwr_d = grant_wr;
          addr_d  = pick_dma ? bus.dma_addr : bus.cpu_addr;
          if (grant_wr) din_d = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        ramwr_d = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (!wr_q && !gnt_q) crd_d = bus.ram_dout;
        if (!wr_q &&  gnt_q) drd_d = bus.ram_dout;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any in-flight access without a response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      ramwr_q <= 1'b0;
      crd_q   <= '0;
      drd_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ramwr_q <= ramwr_d;
      crd_q   <= crd_d;
      drd_q   <= drd_d;
    end
  end

  assign bus.ram_addr   = addr_q;
  assign bus.ram_din    = din_q;
  assign bus.ram_write  = ramwr_q;
  assign bus.gnt_dma    = gnt_q;
  assign bus.cpu_rdata  = crd_q;
  assign bus.dma_rdata  = drd_q;
  assign bus.dma_ready  = (state_q == S_RESP) && gnt_q;
  assign bus.dma_rvalid = (state_q == S_RESP) && gnt_q && !wr_q;
  assign bus.cpu_wait   = cpu_req && !((state_q == S_RESP) && !gnt_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 512x16 synchronous RAM.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   fails = 0;

  mem_arbiter_if #(.AW(9), .DW(16)) bus ();

  mem_arbiter #(.AW(9), .DW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM: write on the strobe, read data one cycle after the address.
  logic [15:0] mem [512];
  always @(posedge clk) begin
    if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  initial begin
    bus.cpu_cmd   = 2'b00;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dma_valid = 1'b0;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = '0;
    bus.dma_wdata = '0;

    // Reset state
    nedge(); nedge();
    chk("rst_ram_addr",  32'(bus.ram_addr), 0);
    chk("rst_ram_din",   32'(bus.ram_din), 0);
    chk("rst_ram_write", 32'(bus.ram_write), 0);
    chk("rst_gnt",       32'(bus.gnt_dma), 0);
    chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    chk("rst_dma_rdata", 32'(bus.dma_rdata), 0);
    chk("rst_dma_ready", 32'(bus.dma_ready), 0);
    chk("rst_dma_rvalid",32'(bus.dma_rvalid), 0);
    chk("rst_cpu_wait",  32'(bus.cpu_wait), 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nedge();
      chk("idle_ram_write", 32'(bus.ram_write), 0);
      chk("idle_dma_ready", 32'(bus.dma_ready), 0);
      chk("idle_cpu_wait",  32'(bus.cpu_wait), 0);
    end

    // cpu write 1234 @5
    bus.cpu_cmd = 2'b10; bus.cpu_addr = 9'd5; bus.cpu_wdata = 16'h1234;
    #1 chk("cw_wait_n", 32'(bus.cpu_wait), 1);
    nedge();
    chk("cw_ram_write_n1", 32'(bus.ram_write), 1);
    chk("cw_ram_addr",     32'(bus.ram_addr), 5);
    chk("cw_ram_din",      32'(bus.ram_din), 32'h1234);
    chk("cw_wait_n1",      32'(bus.cpu_wait), 1);
    chk("cw_gnt",          32'(bus.gnt_dma), 0);
    nedge();
    chk("cw_ram_write_n2", 32'(bus.ram_write), 0);
    chk("cw_wait_n2",      32'(bus.cpu_wait), 0);
    chk("cw_dma_ready_n2", 32'(bus.dma_ready), 0);
    bus.cpu_cmd = 2'b00;
    nedge();
    chk("cw_ram_write_n3", 32'(bus.ram_write), 0);

    // cpu read @5
    bus.cpu_cmd = 2'b01;
    nedge();
    chk("cr_ram_write_n1", 32'(bus.ram_write), 0);
    chk("cr_wait_n1",      32'(bus.cpu_wait), 1);
    nedge();
    chk("cr_wait_n2",      32'(bus.cpu_wait), 0);
    bus.cpu_cmd = 2'b00;
    nedge();
    chk("cr_rdata", 32'(bus.cpu_rdata), 32'h1234);

    // DMA write ABCD @1FF
    bus.dma_valid = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 9'h1FF; bus.dma_wdata = 16'hABCD;
    nedge();
    chk("dw_gnt",       32'(bus.gnt_dma), 1);
    chk("dw_ram_write", 32'(bus.ram_write), 1);
    chk("dw_ram_addr",  32'(bus.ram_addr), 32'h1FF);
    chk("dw_ready_n1",  32'(bus.dma_ready), 0);
    nedge();
    chk("dw_ready_n2",  32'(bus.dma_ready), 1);
    chk("dw_rvalid_n2", 32'(bus.dma_rvalid), 0);
    bus.dma_valid = 1'b0;
    nedge();
    chk("dw_ready_n3",  32'(bus.dma_ready), 0);

    // cpu read @1FF sees the DMA write
    bus.cpu_cmd = 2'b01; bus.cpu_addr = 9'h1FF;
    nedge(); nedge();
    bus.cpu_cmd = 2'b00;
    nedge();
    chk("cr1ff_rdata", 32'(bus.cpu_rdata), 32'hABCD);

    // DMA write 5A5A @7 for the reset test
    bus.dma_valid = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 9'd7; bus.dma_wdata = 16'h5A5A;
    nedge(); nedge();
    bus.dma_valid = 1'b0;
    nedge();

    // Reserved command: no activity
    bus.cpu_cmd = 2'b11; bus.cpu_addr = 9'd3;
    for (int i = 0; i < 10; i++) begin
      nedge();
      chk("rsv_wait",      32'(bus.cpu_wait), 0);
      chk("rsv_ram_write", 32'(bus.ram_write), 0);
      chk("rsv_ram_addr",  32'(bus.ram_addr), 7);
    end
    bus.cpu_cmd = 2'b00;

    // Round robin from reset: cpu read @5 and DMA read @1FF held
    reset = 1'b1;
    bus.cpu_cmd = 2'b01; bus.cpu_addr = 9'd5;
    bus.dma_valid = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 9'h1FF;
    nedge();
    reset = 1'b0;
    #1 chk("rr_wait_r0", 32'(bus.cpu_wait), 1);
    for (int k = 0; k < 4; k++) begin
      nedge();
      chk("rr_gnt",  32'(bus.gnt_dma), 32'(k % 2));
      chk("rr_addr", 32'(bus.ram_addr), (k % 2) ? 32'h1FF : 32'd5);
      nedge();
      if (k % 2 == 0) begin
        chk("rr_cpu_wait_resp", 32'(bus.cpu_wait), 0);
        chk("rr_dma_ready_off", 32'(bus.dma_ready), 0);
      end else begin
        chk("rr_dma_ready",     32'(bus.dma_ready), 1);
        chk("rr_dma_rvalid",    32'(bus.dma_rvalid), 1);
        chk("rr_cpu_wait_hold", 32'(bus.cpu_wait), 1);
      end
      if (k == 3) begin
        bus.cpu_cmd = 2'b00; bus.dma_valid = 1'b0;
      end
      nedge();
      if (k % 2 == 0) chk("rr_cpu_rdata", 32'(bus.cpu_rdata), 32'h1234);
      else            chk("rr_dma_rdata", 32'(bus.dma_rdata), 32'hABCD);
    end

    // DMA read @7 aborted by reset in ACCESS, then retried
    bus.dma_valid = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 9'd7;
    nedge();
    chk("ra_gnt_access", 32'(bus.gnt_dma), 1);
    reset = 1'b1;
    nedge();
    chk("ra_ready",  32'(bus.dma_ready), 0);
    chk("ra_rvalid", 32'(bus.dma_rvalid), 0);
    chk("ra_rdata",  32'(bus.dma_rdata), 0);
    reset = 1'b0;
    nedge();
    chk("ra_ready_access", 32'(bus.dma_ready), 0);
    nedge();
    chk("ra_ready_resp",  32'(bus.dma_ready), 1);
    chk("ra_rvalid_resp", 32'(bus.dma_rvalid), 1);
    bus.dma_valid = 1'b0;
    nedge();
    chk("ra_rdata_after", 32'(bus.dma_rdata), 32'h5A5A);
    chk("ra_ready_after", 32'(bus.dma_ready), 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single-ported instruction/data RAM. It shares the RAM between the cpu (mem_cmd/mem_addr style port, stalled via cpu_wait) and a DMA/program-loader port using a valid/ready handshake. Round-robin arbitration resolves same-cycle requests. It sits between cpu, the loader and the RAM instance at the top level, and fully sequences each RAM access.

## Interface
- AW, 9, address width (512-word RAM)
- DW, 16, data width
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  synchronous, active-high
- cpu_cmd  in  2  00 none, 01 read, 10 write, 11 reserved (treated as none)
- cpu_addr  in  AW  cpu word address
- cpu_wdata  in  DW  cpu write data
- cpu_rdata  out  DW  last cpu read result (registered)
- cpu_wait  out  1  cpu access pending, not yet complete
- dma_valid  in  1  DMA request
- dma_we  in  1  1 write, 0 read
- dma_addr  in  AW  DMA word address
- dma_wdata  in  DW  DMA write data
- dma_ready  out  1  one-cycle pulse: DMA request completed
- dma_rvalid  out  1  one-cycle pulse with dma_ready on reads
- dma_rdata  out  DW  last DMA read result (registered)
- ram_addr  out  AW  RAM address (registered)
- ram_write  out  1  RAM write enable (registered)
- ram_din  out  DW  RAM write data (registered)
- ram_dout  in  DW  RAM read data, valid one cycle after address is presented
- gnt_dma  out  1  owner of current/last access (0 cpu, 1 DMA)

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: cpu_req = cpu_cmd∈{01,10}; dma_req = dma_valid.
  - No request: stay IDLE.
  - One request: grant it.
  - Both: grant the port not in last_grant.
  - On the grant edge: latch owner into gnt_dma/last_grant; load ram_addr, ram_din (write data, else hold) and ram_write (1 only for writes); go to ACCESS.
- ACCESS: RAM samples the address/write. On the edge: ram_write→0, go to RESP.
- RESP: ram_dout valid.
  - Owner cpu: cpu_wait=0. Read: cpu_rdata←ram_dout at the edge.
  - Owner DMA: dma_ready=1. Read: dma_rvalid=1, dma_rdata←ram_dout at the edge.
  - Go to IDLE.
- cpu_wait = cpu_req && !(state==RESP && gnt_dma==0). It is combinational.
- cpu_cmd/addr/wdata and DMA fields must stay stable from request until completion. They are sampled only at the IDLE grant edge.
- A request still presented in the IDLE cycle after its RESP is a new access. The requester must drop or change it.
- Reserved cpu_cmd=11: no request, no RAM activity, cpu_wait=0.
- Address arithmetic: none. Addresses pass through unmodified. No wrap or bounds logic.
- Reset edge:
  - state→IDLE.
  - last_grant→1 (DMA), so the cpu wins the first tie.
  - gnt_dma→0; ram_addr, ram_din, cpu_rdata, dma_rdata→0; ram_write→0.
  - dma_ready and dma_rvalid are 0 in the first cycle after reset.
  - cpu_wait follows its equation (0 when cpu_cmd is none).
- Reset mid-operation:
  - A write in ACCESS at the reset edge still commits, because the RAM samples on that same edge.
  - No RESP/ready/rvalid is produced for the aborted access.
  - Pending requests are re-arbitrated from IDLE after reset deasserts.

## Timing
- Latency: request seen in IDLE cycle n → ACCESS cycle n+1 → RESP cycle n+2 (completion visible) → IDLE cycle n+3.
- Throughput: one access per 3 cycles. The earliest next grant edge is the end of cycle n+3.
- cpu_wait is high in cycles n, n+1 and low in n+2.
- cpu_rdata/dma_rdata are updated at the end of n+2 and hold until the next read by the same port.
- Round-robin guarantees each waiting port is granted within one intervening access (≤6 cycles).
- ram_write is high for exactly one cycle (ACCESS) per write.

## Test plan
- Reset with cpu_cmd=00, dma_valid=0 → all outputs 0, cpu_wait=0, stays IDLE; ram_write never asserts.
- cpu write 16'h1234 @9'd5, then cpu read @9'd5:
  - write: ram_write=1 only in cycle n+1 with ram_addr=5, ram_din=1234; cpu_wait high 2 cycles.
  - read: cpu_rdata=16'h1234 in cycle after RESP.
- DMA write 16'hABCD @9'h1FF: dma_ready pulses one cycle in n+2 with dma_rvalid=0. Then cpu read @9'h1FF → cpu_rdata=16'hABCD.
- cpu read and DMA read held continuously from reset release → grants alternate cpu, DMA, cpu, DMA. gnt_dma=0,1,0,1 at successive ACCESS cycles, 3 cycles apart. Neither port waits more than 6 cycles.
- cpu_cmd=11 for 10 cycles with dma_valid=0 → cpu_wait=0, ram_write=0, state stays IDLE.
- DMA read @9'd7 with reset asserted during ACCESS → no dma_ready/dma_rvalid, dma_rdata=0. After deassert, the still-valid request completes with dma_rdata=RAM[7] 3 cycles later.
